// File: rtl/fp_align_shifter_pipe.sv
// Pipelined mantissa alignment shifter. It right-shifts {hidden, mantissa, 3'b000} by the
// exponent difference (saturated at the vector width) and collects guard/round/sticky
// bits. The larger exponent travels alongside the operand.
// The log2 barrel is split across PIPE_STAGES register stages, with the higher shift bits
// handled first. Each stage has a valid/ready handshake, and empty stages fill while the
// output is stalled.
// Optional feature: define ALIGN_SHIFT_OVF_FLAG_EN to add shift_ovf_out. It flags operands
// whose shift amount was >= the vector width, meaning the operand went entirely into sticky.
module fp_align_shifter_pipe #(
  parameter int unsigned MENT_WIDTH  = 23,
  parameter int unsigned EXPO_WIDTH  = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [MENT_WIDTH-1:0] smaller_operand_in,
  input  logic                  hidden_bit_in,
  input  logic [EXPO_WIDTH-1:0] rshift_in,
  input  logic [EXPO_WIDTH-1:0] expo_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [MENT_WIDTH:0]   smaller_operand_out,
  output logic                  guard_out,
  output logic                  round_out,
  output logic                  sticky_out,
  output logic [EXPO_WIDTH-1:0] expo_out
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
  ,
  output logic                  shift_ovf_out
`endif
);

  localparam int unsigned W           = MENT_WIDTH + 4;
  localparam int unsigned NumLevels   = $clog2(W + 1);
  localparam int unsigned LvlPerStage = (NumLevels + PIPE_STAGES - 1) / PIPE_STAGES;
  // The last stage consumes its shift bits and does not register them.
  localparam int unsigned ShamtStages = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
  localparam int unsigned Last        = PIPE_STAGES - 1;

  // Input preparation: extended vector and saturated shift amount.
  logic [W-1:0]           ext_in;
  logic [31:0]            rshift_ext;
  logic [NumLevels-1:0]   shamt_in;

  assign ext_in     = {hidden_bit_in, smaller_operand_in, 3'b000};
  assign rshift_ext = 32'(rshift_in);
  assign shamt_in   = (rshift_ext >= 32'(W)) ? NumLevels'(W) : NumLevels'(rshift_ext);

  // Per-stage state and next-state.
  logic [PIPE_STAGES-1:0]                 valid_q;
  logic [PIPE_STAGES-1:0]                 load;
  logic [PIPE_STAGES-1:0]                 src_valid;
  logic [PIPE_STAGES-1:0]                 take;
  logic [PIPE_STAGES-1:0][W-1:0]          src_vec;
  logic [PIPE_STAGES-1:0][W-1:0]          vec_q;
  logic [PIPE_STAGES-1:0][W-1:0]          vec_d;
  logic [PIPE_STAGES-1:0]                 src_sticky;
  logic [PIPE_STAGES-1:0]                 sticky_q;
  logic [PIPE_STAGES-1:0]                 sticky_d;
  logic [PIPE_STAGES-1:0][NumLevels-1:0]  src_shamt;
  logic [ShamtStages-1:0][NumLevels-1:0]  shamt_q;
  logic [PIPE_STAGES-1:0][EXPO_WIDTH-1:0] src_expo;
  logic [PIPE_STAGES-1:0][EXPO_WIDTH-1:0] expo_q;
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
  logic                                   ovf_in;
  logic [PIPE_STAGES-1:0]                 src_ovf;
  logic [PIPE_STAGES-1:0]                 ovf_q;

  assign ovf_in = (rshift_ext >= 32'(W));
`endif

  // Each stage reads the stage ahead of it, and stage 0 reads the input port.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign src_vec[k]    = ext_in;
      assign src_sticky[k] = 1'b0;
      assign src_shamt[k]  = shamt_in;
      assign src_expo[k]   = expo_in;
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
      assign src_ovf[k]    = ovf_in;
`endif
    end else begin : g_next
      assign src_vec[k]    = vec_q[k-1];
      assign src_sticky[k] = sticky_q[k-1];
      assign src_shamt[k]  = shamt_q[k-1];
      assign src_expo[k]   = expo_q[k-1];
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
      assign src_ovf[k]    = ovf_q[k-1];
`endif
    end
  end

  // Handshake: a stage loads when it is empty or when its content moves forward this cycle.
  always_comb begin
    logic downstream_ready;
    downstream_ready = ready_out;
    load             = '0;
    src_valid        = '0;
    for (int i = int'(Last); i >= 0; i--) begin
      load[i]          = ~valid_q[i] | downstream_ready;
      downstream_ready = ~valid_q[i] | downstream_ready;
    end
    src_valid[0] = valid_in;
    for (int i = 1; i < int'(PIPE_STAGES); i++) begin
      src_valid[i] = valid_q[i-1];
    end
    take = load & src_valid;
  end

  assign ready_in = load[0];

  // Barrel levels: shift bit b belongs to stage (NumLevels-1-b)/LvlPerStage.
  always_comb begin
    logic [W-1:0]   v;
    logic           st;
    logic [2*W-1:0] shifted;
    vec_d    = '0;
    sticky_d = '0;
    for (int k = 0; k < int'(PIPE_STAGES); k++) begin
      v       = src_vec[k];
      st      = src_sticky[k];
      shifted = '0;
      for (int b = int'(NumLevels) - 1; b >= 0; b--) begin
        if (((int'(NumLevels) - 1 - b) / int'(LvlPerStage)) == k && src_shamt[k][b]) begin
          // The low half of the widened vector holds exactly the bits shifted out.
          shifted = {v, {W{1'b0}}} >> (1 << b);
          v       = shifted[2*W-1:W];
          st      = st | (|shifted[W-1:0]);
        end
      end
      vec_d[k]    = v;
      sticky_d[k] = st;
    end
  end

  // Stage registers. Data loads only with a real operand, so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      vec_q    <= '0;
      sticky_q <= '0;
      shamt_q  <= '0;
      expo_q   <= '0;
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
      ovf_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < int'(PIPE_STAGES); i++) begin
        if (load[i]) begin
          valid_q[i] <= src_valid[i];
        end
        if (take[i]) begin
          vec_q[i]    <= vec_d[i];
          sticky_q[i] <= sticky_d[i];
          expo_q[i]   <= src_expo[i];
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
          ovf_q[i]    <= src_ovf[i];
`endif
        end
      end
      for (int i = 0; i < int'(ShamtStages); i++) begin
        if (take[i]) begin
          shamt_q[i] <= src_shamt[i];
        end
      end
    end
  end

  assign valid_out           = valid_q[Last];
  assign smaller_operand_out = vec_q[Last][W-1:3];
  assign guard_out           = vec_q[Last][2];
  assign round_out           = vec_q[Last][1];
  assign sticky_out          = vec_q[Last][0] | sticky_q[Last];
  assign expo_out            = expo_q[Last];
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
  assign shift_ovf_out       = ovf_q[Last];
`endif

endmodule

// File: tb/tb_fp_align_shifter_pipe.sv
// Bench for fp_align_shifter_pipe. The main instance (2 stages) gets directed cases,
// back-pressure, mid-flight reset and random handshaking. Two more instances (1 and 5
// stages) get a random stream that checks fixed latency. Reference values come from
// arithmetic on the extended significand.
module tb_fp_align_shifter_pipe;

  localparam int unsigned MW = 23;
  localparam int unsigned EW = 8;
  localparam int unsigned W  = MW + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

  // Main instance bus (2 stages)
  logic          a_valid, a_ready_in, a_ready_out, a_hid, a_valid_out, a_g, a_r, a_s;
  logic [MW-1:0] a_mant;
  logic [EW-1:0] a_shift, a_expo, a_expo_out;
  logic [MW:0]   a_op;
  // Latency bus shared by the 1- and 5-stage instances
  logic          b_valid, b_hid, b_ready_out;
  logic [MW-1:0] b_mant;
  logic [EW-1:0] b_shift, b_expo;
  logic          p1_ready_in, p1_valid_out, p1_g, p1_r, p1_s;
  logic          p5_ready_in, p5_valid_out, p5_g, p5_r, p5_s;
  logic [MW:0]   p1_op, p5_op;
  logic [EW-1:0] p1_expo_out, p5_expo_out;
  logic          a_ovf, p1_ovf, p5_ovf;
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
  localparam bit OvfOn = 1'b1;
`else
  localparam bit OvfOn = 1'b0;
  assign a_ovf  = 1'b0;
  assign p1_ovf = 1'b0;
  assign p5_ovf = 1'b0;
`endif

  assign b_ready_out = 1'b1;

  fp_align_shifter_pipe #(.MENT_WIDTH(MW), .EXPO_WIDTH(EW), .PIPE_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .valid_in(a_valid), .ready_in(a_ready_in),
    .smaller_operand_in(a_mant), .hidden_bit_in(a_hid), .rshift_in(a_shift),
    .expo_in(a_expo), .valid_out(a_valid_out), .ready_out(a_ready_out),
    .smaller_operand_out(a_op), .guard_out(a_g), .round_out(a_r), .sticky_out(a_s),
    .expo_out(a_expo_out)
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
    , .shift_ovf_out(a_ovf)
`endif
  );

  fp_align_shifter_pipe #(.MENT_WIDTH(MW), .EXPO_WIDTH(EW), .PIPE_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .valid_in(b_valid), .ready_in(p1_ready_in),
    .smaller_operand_in(b_mant), .hidden_bit_in(b_hid), .rshift_in(b_shift),
    .expo_in(b_expo), .valid_out(p1_valid_out), .ready_out(b_ready_out),
    .smaller_operand_out(p1_op), .guard_out(p1_g), .round_out(p1_r), .sticky_out(p1_s),
    .expo_out(p1_expo_out)
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
    , .shift_ovf_out(p1_ovf)
`endif
  );

  fp_align_shifter_pipe #(.MENT_WIDTH(MW), .EXPO_WIDTH(EW), .PIPE_STAGES(5)) u_dut5 (
    .clk(clk), .rst(rst), .valid_in(b_valid), .ready_in(p5_ready_in),
    .smaller_operand_in(b_mant), .hidden_bit_in(b_hid), .rshift_in(b_shift),
    .expo_in(b_expo), .valid_out(p5_valid_out), .ready_out(b_ready_out),
    .smaller_operand_out(p5_op), .guard_out(p5_g), .round_out(p5_r), .sticky_out(p5_s),
    .expo_out(p5_expo_out)
`ifdef ALIGN_SHIFT_OVF_FLAG_EN
    , .shift_ovf_out(p5_ovf)
`endif
  );

  function automatic logic [63:0] pack(input logic v, input logic [MW:0] op, input logic g,
                                       input logic r, input logic s, input logic [EW-1:0] e,
                                       input logic o);
    return {27'd0, v, op, g, r, s, e, o};
  endfunction

  // Reference: R = E >> min(shift, W), with any lost bit OR-ed into R[0].
  function automatic logic [63:0] model(input logic [MW-1:0] mant, input logic hid,
                                        input logic [EW-1:0] sh, input logic [EW-1:0] ex);
    longint unsigned e, r, lost;
    int              s;
    e    = 64'({hid, mant, 3'b000});
    s    = (int'(sh) > int'(W)) ? int'(W) : int'(sh);
    r    = e >> s;
    lost = e & ((64'd1 << s) - 64'd1);
    if (lost != 64'd0) r = r | 64'd1;
    return pack(1'b1, r[26:3], r[2], r[1], r[0], ex, OvfOn && (int'(sh) >= int'(W)));
  endfunction

  logic [63:0] a_obs, p1_obs, p5_obs;
  assign a_obs  = pack(a_valid_out, a_op, a_g, a_r, a_s, a_expo_out, a_ovf);
  assign p1_obs = pack(p1_valid_out, p1_op, p1_g, p1_r, p1_s, p1_expo_out, p1_ovf);
  assign p5_obs = pack(p5_valid_out, p5_op, p5_g, p5_r, p5_s, p5_expo_out, p5_ovf);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic rand_op(output logic [MW-1:0] m, output logic h, output logic [EW-1:0] s,
                         output logic [EW-1:0] e);
    m = MW'($urandom >> $urandom_range(0, 31));
    h = 1'($urandom_range(0, 1));
    s = ($urandom_range(0, 9) < 7) ? EW'($urandom_range(0, 30)) : EW'($urandom_range(0, 255));
    e = EW'($urandom);
  endtask

  // One operand through the idle 2-stage instance with ready_out high.
  task automatic send_one(input string tag, input logic [MW-1:0] m, input logic h,
                          input logic [EW-1:0] s, input logic [EW-1:0] e,
                          input logic [63:0] exp_val);
    int lat;
    a_valid = 1'b1; a_mant = m; a_hid = h; a_shift = s; a_expo = e;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(a_ready_in), 64'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!a_valid_out && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_val"}, a_obs, exp_val);
    check({tag, "_mdl"}, a_obs, model(m, h, s, e));
    @(posedge clk); #1;
  endtask

  logic [MW-1:0] bp_m [4];
  logic          bp_h [4];
  logic [EW-1:0] bp_s [4];
  logic [EW-1:0] bp_e [4];
  logic [63:0]   sbq [$];
  logic [63:0]   exp1 [int];
  logic [63:0]   exp5 [int];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          acc, got, first, last, sent, c;
    logic        prev_stall;
    logic [63:0] prev_obs;
    rst = 1'b1; a_valid = 1'b0; a_ready_out = 1'b1; a_mant = '0; a_hid = 1'b0;
    a_shift = '0; a_expo = '0; b_valid = 1'b0; b_mant = '0; b_hid = 1'b0;
    b_shift = '0; b_expo = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a", a_obs, 64'd0);
    check("rst_p1", p1_obs, 64'd0);
    check("rst_p5", p5_obs, 64'd0);
    check("rst_rdy", 64'(a_ready_in), 64'd1);
    @(posedge clk); #1;

    // Directed cases
    send_one("d_sh1", 23'h400000, 1'b1, 8'd1, 8'h85,
             pack(1'b1, 24'h600000, 1'b0, 1'b0, 1'b0, 8'h85, 1'b0));
    send_one("d_sh25", 23'h400000, 1'b1, 8'd25, 8'h85,
             pack(1'b1, 24'h0, 1'b0, 1'b1, 1'b1, 8'h85, 1'b0));
    send_one("d_sh26", 23'h400000, 1'b1, 8'd26, 8'h85,
             pack(1'b1, 24'h0, 1'b0, 1'b0, 1'b1, 8'h85, 1'b0));
    send_one("d_shff", 23'h0, 1'b1, 8'hff, 8'h3c,
             pack(1'b1, 24'h0, 1'b0, 1'b0, 1'b1, 8'h3c, OvfOn));
    send_one("d_sh0", 23'h012345, 1'b1, 8'd0, 8'h7f,
             pack(1'b1, 24'h812345, 1'b0, 1'b0, 1'b0, 8'h7f, 1'b0));
    send_one("d_sh27", 23'h000001, 1'b0, 8'd27, 8'h01,
             pack(1'b1, 24'h0, 1'b0, 1'b0, 1'b1, 8'h01, OvfOn));

    // Back-pressure: four operands, output stalled for five cycles
    for (int i = 0; i < 4; i++) rand_op(bp_m[i], bp_h[i], bp_s[i], bp_e[i]);
    a_ready_out = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      a_valid = (acc < 4);
      a_mant = bp_m[acc % 4]; a_hid = bp_h[acc % 4]; a_shift = bp_s[acc % 4];
      a_expo = bp_e[acc % 4];
      @(negedge clk);
      if (a_valid_out) check("bp_hold", a_obs, model(bp_m[0], bp_h[0], bp_s[0], bp_e[0]));
      if (k >= 2) begin
        check("bp_rdy_low", 64'(a_ready_in), 64'd0);
        check("bp_vout", 64'(a_valid_out), 64'd1);
      end
      if (a_valid && a_ready_in) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", 64'(acc), 64'd2);
    a_ready_out = 1'b1;
    got = 0; first = -1; last = -1;
    for (int k = 0; k < 20 && got < 4; k++) begin
      a_valid = (acc < 4);
      a_mant = bp_m[acc % 4]; a_hid = bp_h[acc % 4]; a_shift = bp_s[acc % 4];
      a_expo = bp_e[acc % 4];
      @(negedge clk);
      if (a_valid_out) begin
        check("bp_order", a_obs, model(bp_m[got], bp_h[got], bp_s[got], bp_e[got]));
        if (first < 0) first = k;
        last = k;
        got++;
      end
      if (a_valid && a_ready_in) acc++;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    check("bp_count", 64'(got), 64'd4);
    check("bp_consec", 64'(last - first), 64'd3);
    @(negedge clk);
    check("bp_extra", 64'(a_valid_out), 64'd0);
    @(posedge clk); #1;

    // Reset with two operands in flight
    a_ready_out = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_valid = 1'b1;
      rand_op(a_mant, a_hid, a_shift, a_expo);
      @(negedge clk);
      check("rst_acc", 64'(a_ready_in), 64'd1);
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush", a_obs, 64'd0);
    check("rst_flush_rdy", 64'(a_ready_in), 64'd1);
    @(posedge clk); #1;
    a_ready_out = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_gone", 64'(a_valid_out), 64'd0);
      @(posedge clk); #1;
    end

    // Random handshaking on the 2-stage instance against a scoreboard
    prev_stall = 1'b0;
    prev_obs   = '0;
    for (int k = 0; k < 3000; k++) begin
      a_valid     = ($urandom_range(0, 9) < 7);
      a_ready_out = ($urandom_range(0, 9) < 7);
      rand_op(a_mant, a_hid, a_shift, a_expo);
      @(negedge clk);
      if (prev_stall) check("rnd_hold", a_obs, prev_obs);
      if (a_valid_out && a_ready_out) begin
        if (sbq.size() == 0) check("rnd_extra", a_obs, 64'd0);
        else check("rnd_data", a_obs, sbq.pop_front());
      end
      if (a_valid && a_ready_in) sbq.push_back(model(a_mant, a_hid, a_shift, a_expo));
      prev_stall = a_valid_out && !a_ready_out;
      prev_obs   = a_obs;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    a_ready_out = 1'b1;
    for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
      @(negedge clk);
      if (a_valid_out) check("rnd_drain", a_obs, sbq.pop_front());
      @(posedge clk); #1;
    end
    check("rnd_left", 64'(sbq.size()), 64'd0);

    // Fixed-latency stream into the 1- and 5-stage instances
    sent = 0;
    c = 0;
    while ((sent < 10000 || exp1.num() != 0 || exp5.num() != 0) && c < 20000) begin
      b_valid = (sent < 10000) && ($urandom_range(0, 9) < 8);
      rand_op(b_mant, b_hid, b_shift, b_expo);
      @(negedge clk);
      if (b_valid) begin
        check("p1_rdy", 64'(p1_ready_in), 64'd1);
        check("p5_rdy", 64'(p5_ready_in), 64'd1);
      end
      if (exp1.exists(c) || p1_valid_out) begin
        check("p1_lat", p1_obs, exp1.exists(c) ? exp1[c] : 64'd0);
        if (exp1.exists(c)) exp1.delete(c);
      end
      if (exp5.exists(c) || p5_valid_out) begin
        check("p5_lat", p5_obs, exp5.exists(c) ? exp5[c] : 64'd0);
        if (exp5.exists(c)) exp5.delete(c);
      end
      if (b_valid && p1_ready_in) exp1[c + 1] = model(b_mant, b_hid, b_shift, b_expo);
      if (b_valid && p5_ready_in) exp5[c + 5] = model(b_mant, b_hid, b_shift, b_expo);
      if (b_valid) sent++;
      @(posedge clk); #1;
      c++;
    end
    b_valid = 1'b0;
    check("p1_left", 64'(exp1.num()), 64'd0);
    check("p5_left", 64'(exp5.num()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
